// File: rtl/smg_display_ctrl.sv
// smg_display_ctrl: 4-digit 7-seg scan sequencer with slot brightness, enable gate and double-buffered load.
// Define SMG_LZB_EN to enable leading-zero blanking of digits 0..2.
module smg_display_ctrl #(
  parameter int SLOT_CYC = 4,
  parameter int BRIGHT_W = 3
) (
  input  logic                CLK1MS,
  input  logic                RSTn,
  input  logic                Disp_En,
  input  logic [BRIGHT_W-1:0] Bright,
  input  logic                Load_Req,
  input  logic [15:0]         Load_Data,
  output logic                Load_Ack,
  output logic [3:0]          Scan_Sig,
  output logic [3:0]          Digit_Data,
  output logic                Frame_Start
);
  localparam int CW = (SLOT_CYC > 2) ? $clog2(SLOT_CYC) : 1;
  logic [CW-1:0] c_q, c_d;
  logic [1:0] d_q, d_d;
  logic [15:0] act_q, act_d, sh_q, sh_d;
  logic pend_q, pend_d, run_q, run_d;
  logic [3:0] scan_q, scan_d, data_q, data_d;
  logic fs_q, fs_d, ack_q, ack_d;
  logic c_wrap, bound, blank, lit;
  logic [31:0] bs;
  always_comb begin
    c_wrap = 32'(c_q) == 32'(SLOT_CYC - 1);
    bound  = c_wrap && d_q == 2'd3;
    c_d    = c_wrap ? '0 : c_q + 1'b1;
    d_d    = c_wrap ? d_q + 2'd1 : d_q;
    bs     = 32'(Bright) > 32'(SLOT_CYC) ? 32'(SLOT_CYC) : 32'(Bright);
    lit    = 32'(c_q) + bs >= 32'(SLOT_CYC);
`ifdef SMG_LZB_EN
    blank  = d_q == 2'd0 ? act_q[15:12] == 4'h0 :
             d_q == 2'd1 ? act_q[15:8] == 8'h00 :
             d_q == 2'd2 ? act_q[15:4] == 12'h000 : 1'b0;
`else
    blank  = 1'b0;
`endif
    scan_d = Disp_En && lit && !blank ? 4'b1000 >> d_q : 4'b0000;
    data_d = 4'(act_q >> {~d_q, 2'b00});
    fs_d   = run_q && d_q == 2'd0 && c_q == '0;
    ack_d  = Load_Req && !pend_q;
    // A pending swap blocks new captures, so a boundary swap and a capture never share a clock
    act_d  = bound && pend_q ? sh_q : act_q;
    pend_d = ack_d || (pend_q && !bound);
    sh_d   = ack_d ? Load_Data : sh_q;
    run_d  = 1'b1;
  end
  always_ff @(posedge CLK1MS or negedge RSTn) begin
    if (!RSTn) begin
      c_q    <= '0;
      d_q    <= '0;
      act_q  <= '0;
      sh_q   <= '0;
      pend_q <= 1'b0;
      run_q  <= 1'b0;
      scan_q <= '0;
      data_q <= '0;
      fs_q   <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      c_q    <= c_d;
      d_q    <= d_d;
      act_q  <= act_d;
      sh_q   <= sh_d;
      pend_q <= pend_d;
      run_q  <= run_d;
      scan_q <= scan_d;
      data_q <= data_d;
      fs_q   <= fs_d;
      ack_q  <= ack_d;
    end
  end
  assign Scan_Sig    = scan_q;
  assign Digit_Data  = data_q;
  assign Frame_Start = fs_q;
  assign Load_Ack    = ack_q;
endmodule

// File: tb/tb_smg_display_ctrl.sv
// tb_smg_display_ctrl: scoreboard-checked bench for smg_display_ctrl; honours SMG_LZB_EN like the DUT.
module tb_smg_display_ctrl;
  localparam int S = 4;
  logic clk = 0, rstn = 0, en = 0, req = 0;
  logic [2:0] bright = 0;
  logic [15:0] din = 0;
  logic ack, fs;
  logic [3:0] scan, data;
  smg_display_ctrl #(.SLOT_CYC(S), .BRIGHT_W(3)) dut (
    .CLK1MS(clk), .RSTn(rstn), .Disp_En(en), .Bright(bright), .Load_Req(req),
    .Load_Data(din), .Load_Ack(ack), .Scan_Sig(scan), .Digit_Data(data), .Frame_Start(fs));
  always #5 clk = ~clk;
  typedef struct packed {logic [3:0] scan; logic [3:0] data; logic fs; logic ack;} out_t;
  typedef struct {logic en; int bright; int exp_lit;} cfg_t;
  out_t q[$];
  int n_cmp = 0, n_bad = 0;
  int md, mc, lit_cnt, fs_cnt;
  logic [15:0] mact, msh;
  logic mpend, mrun;
  logic [3:0] dig [4];
  task automatic check(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    md = 0; mc = 0; mact = 0; msh = 0; mpend = 0; mrun = 0;
    q.delete();
  endtask
  task automatic step();
    out_t e, o;
    int bs;
    logic [15:0] sh;
    logic blank;
    bs = (int'(bright) > S) ? S : int'(bright);
    sh = mact >> (4 * (3 - md));
`ifdef SMG_LZB_EN
    blank = (md < 3) && (sh == 16'h0);
`else
    blank = 1'b0;
`endif
    e.scan = (en && mc >= S - bs && !blank) ? 4'(1 << (3 - md)) : 4'h0;
    e.data = sh[3:0];
    e.fs   = mrun && md == 0 && mc == 0;
    e.ack  = req && !mpend;
    q.push_back(e);
    if (mpend && md == 3 && mc == S - 1) begin mact = msh; mpend = 0; end
    else if (e.ack) begin msh = din; mpend = 1; end
    mrun = 1;
    mc++;
    if (mc == S) begin mc = 0; md = (md + 1) % 4; end
    @(posedge clk); #1;
    o = q.pop_front();
    check("scan", scan, o.scan);
    check("digit_data", data, o.data);
    check("frame_start", fs, o.fs);
    check("load_ack", ack, o.ack);
  endtask
  task automatic align();
    while (!(md == 0 && mc == 0)) step();
  endtask
  task automatic run_frame();
    lit_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 4 * S; i++) begin
      step();
      if (scan != 0) lit_cnt++;
      fs_cnt += int'(fs);
      if (i % S == 0) dig[i / S] = data;
    end
  endtask
  task automatic check_digits(input string nm, input logic [15:0] v);
    logic [15:0] t;
    for (int k = 0; k < 4; k++) begin
      t = v >> (4 * (3 - k));
      check(nm, dig[k], t[3:0]);
    end
  endtask
  task automatic load(input logic [15:0] v);
    int n = 0;
    align(); step(); step();
    req = 1; din = v;
    step();
    while (!ack && n < 40) begin step(); n++; end
    check("load_ack_seen", ack, 1);
    req = 0;
  endtask
  cfg_t tbl [7];
  initial begin
    int n;
    tbl[0] = '{1'b1, 4, 16}; tbl[1] = '{1'b1, 1, 4}; tbl[2] = '{1'b1, 0, 0};
    tbl[3] = '{1'b1, 7, 16}; tbl[4] = '{1'b0, 4, 0}; tbl[5] = '{1'b1, 2, 8};
    tbl[6] = '{1'b1, 3, 12};
    model_reset();
    en = 1; bright = 4;
    #12;
    check("rst_scan", scan, 0); check("rst_data", data, 0);
    check("rst_fs", fs, 0); check("rst_ack", ack, 0);
    rstn = 1;
    #1 check("post_release_scan", scan, 0);
    run_frame();
    check("first_frame_lit", lit_cnt, 16);
    check("first_frame_fs", fs_cnt, 0);
    foreach (tbl[i]) begin
      en = tbl[i].en; bright = 3'(tbl[i].bright);
      align(); run_frame();
      check("tbl_lit", lit_cnt, tbl[i].exp_lit);
      check("tbl_fs", fs_cnt, 1);
    end
    en = 1; bright = 4;
    load(16'h1234);
    run_frame(); check_digits("old_frame_1234", 16'h0000);
    run_frame(); check_digits("new_frame_1234", 16'h1234);
    align(); step(); step(); step(); step(); step();
    req = 1; din = 16'h5678;
    step(); check("ack_5678", ack, 1);
    din = 16'hABCD;
    n = 0;
    step();
    while (!ack && n < 40) begin step(); n++; end
    check("ack_abcd_on_frame_start", fs, 1);
    check("ack_abcd_data", data, 5);
    req = 0;
    align(); run_frame(); check_digits("frame_abcd", 16'hABCD);
    while (!(md == 3 && mc == S - 1)) step();
    req = 1; din = 16'h7777;
    step(); check("boundary_capture_ack", ack, 1);
    req = 0;
    run_frame(); check_digits("boundary_old", 16'hABCD);
    run_frame(); check_digits("boundary_new", 16'h7777);
    load(16'h0042);
    align(); run_frame();
`ifdef SMG_LZB_EN
    check("lzb_0042_lit", lit_cnt, 8);
`else
    check("lzb_0042_lit", lit_cnt, 16);
`endif
    check_digits("digits_0042", 16'h0042);
    load(16'h0000);
    align(); run_frame();
`ifdef SMG_LZB_EN
    check("lzb_0000_lit", lit_cnt, 4);
`else
    check("lzb_0000_lit", lit_cnt, 16);
`endif
    load(16'h9999);
    load(16'h3141);
    step(); step(); step();
    #3 rstn = 0;
    #1;
    check("async_scan", scan, 0); check("async_data", data, 0);
    check("async_fs", fs, 0); check("async_ack", ack, 0);
    model_reset();
    #2 rstn = 1;
    run_frame(); check_digits("after_rst_frame0", 16'h0000);
    run_frame(); check_digits("after_rst_noswap", 16'h0000);
    check("after_rst_fs", fs_cnt, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
